iob_eth_bd_arbiter: RTL and testbench

Arbiter and sequencer for the Ethernet buffer-descriptor (BD) memory's single port. The port is shared by three requesters: CPU register access, the RX DMA engine and the TX DMA engine. The block grants one owner at a time and forwards the owner's access to the BD memory. It returns one-cycle-latency read data to whichever requester issued the read, and revokes long-held grants when other requesters are waiting.

---
 rtl/iob_eth_bd_arbiter.sv | 166 ++++++++++++++++
 tb/tb_iob_eth_bd_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_eth_bd_arbiter.sv
// Arbitrates the single BD-memory port between CPU, RX DMA and TX DMA and routes read data back.
// Build option: define IOB_ETH_BD_ARB_RR_EN for round-robin selection (default: fixed priority CPU > RX > TX).
module iob_eth_bd_arbiter #(
   parameter int BD_ADDR_W = 8,
   parameter int HOLD_MAX  = 16
) (
   input  logic                   clk_i,
   input  logic                   arst_n_i,
   input  logic                   cke_i,
   input  logic [2:0]             req_i,
   input  logic [3*BD_ADDR_W-1:0] addr_i,
   input  logic [2:0]             wen_i,
   input  logic [95:0]            wdata_i,
   output logic [2:0]             gnt_o,
   output logic [2:0]             rvalid_o,
   output logic [31:0]            rdata_o,
   output logic [1:0]             owner_o,
   output logic                   bd_en_o,
   output logic [BD_ADDR_W-1:0]   bd_addr_o,
   output logic                   bd_wen_o,
   output logic [31:0]            bd_o,
   input  logic [31:0]            bd_i
);
   localparam int               CNT_W       = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
   localparam int               HOLD_LAST_I = (HOLD_MAX > 0) ? HOLD_MAX - 1 : 0;
   localparam logic [CNT_W-1:0] HOLD_LAST   = HOLD_LAST_I[CNT_W-1:0];
   localparam logic [1:0]       NO_OWNER    = 2'd3;

   typedef enum logic {S_IDLE, S_OWNED} state_t;

   state_t           r_state, w_state_next;
   logic [1:0]       r_owner, w_owner_next;
   logic [CNT_W-1:0] r_cnt, w_cnt_next;
   logic             r_rd_pend;
   logic [1:0]       r_rd_owner;
`ifdef IOB_ETH_BD_ARB_RR_EN
   logic [1:0]       r_last_owner;
`endif

   logic [2:0]           w_gnt;
   logic [2:0]           w_comp;
   logic                 w_own_req;
   logic                 w_own_wen;
   logic [1:0]           w_start;
   logic [1:0]           w_pick;
   logic [BD_ADDR_W-1:0] w_addr_m [3];
   logic [31:0]          w_wdata_m [3];

   // First set bit of cand, scanning upward from start with wrap at 3; NO_OWNER if none.
   function automatic logic [1:0] f_pick(input logic [2:0] cand, input logic [1:0] start);
      logic [1:0] res;
      int         t;
      res = NO_OWNER;
      for (int k = 2; k >= 0; k--) begin
         t = int'(start) + k;
         if (t >= 3) t = t - 3;
         if (cand[t]) res = 2'(t);
      end
      return res;
   endfunction

   always_comb begin
      w_gnt = 3'b000;
      if (r_state == S_OWNED) begin
         case (r_owner)
            2'd0:    w_gnt = 3'b001;
            2'd1:    w_gnt = 3'b010;
            2'd2:    w_gnt = 3'b100;
            default: w_gnt = 3'b000;
         endcase
      end
   end

   // Per-requester gating; the one-hot grant turns the OR below into a mux.
   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_req
         assign w_addr_m[gi]  = w_gnt[gi] ? addr_i[gi*BD_ADDR_W +: BD_ADDR_W] : '0;
         assign w_wdata_m[gi] = w_gnt[gi] ? wdata_i[gi*32 +: 32] : '0;
      end
   endgenerate

   assign w_own_req = |(req_i & w_gnt);
   assign w_own_wen = |(wen_i & w_gnt);
   assign w_comp    = req_i & ~w_gnt;

   assign gnt_o     = w_gnt;
   assign owner_o   = r_owner;
   assign bd_en_o   = w_own_req & cke_i;
   assign bd_wen_o  = bd_en_o & w_own_wen;
   assign bd_addr_o = w_addr_m[0] | w_addr_m[1] | w_addr_m[2];
   assign bd_o      = w_wdata_m[0] | w_wdata_m[1] | w_wdata_m[2];

   assign rvalid_o  = (r_rd_pend && cke_i) ? (3'b001 << r_rd_owner) : 3'b000;
   assign rdata_o   = (|rvalid_o) ? bd_i : 32'd0;

`ifdef IOB_ETH_BD_ARB_RR_EN
   assign w_start = (r_last_owner == 2'd2) ? 2'd0 : r_last_owner + 2'd1;
`else
   assign w_start = 2'd0;
`endif

   assign w_pick = f_pick(w_comp, w_start);

   always_comb begin
      w_state_next = r_state;
      w_owner_next = r_owner;
      w_cnt_next   = r_cnt;
      case (r_state)
         S_IDLE: begin
            if (|req_i) begin
               w_state_next = S_OWNED;
               w_owner_next = w_pick;
               w_cnt_next   = '0;
            end
         end
         S_OWNED: begin
            if (!w_own_req) begin
               // Release wins over revocation; hand off directly if anyone else waits.
               w_cnt_next = '0;
               if (|w_comp) begin
                  w_owner_next = w_pick;
               end else begin
                  w_state_next = S_IDLE;
                  w_owner_next = NO_OWNER;
               end
            end else if (|w_comp) begin
               if (HOLD_MAX != 0 && r_cnt == HOLD_LAST) begin
                  w_owner_next = w_pick;
                  w_cnt_next   = '0;
               end else begin
                  w_cnt_next = r_cnt + CNT_W'(1);
               end
            end
         end
         default: begin
            w_state_next = S_IDLE;
            w_owner_next = NO_OWNER;
            w_cnt_next   = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         r_state      <= S_IDLE;
         r_owner      <= NO_OWNER;
         r_cnt        <= '0;
         r_rd_pend    <= 1'b0;
         r_rd_owner   <= 2'd0;
`ifdef IOB_ETH_BD_ARB_RR_EN
         r_last_owner <= 2'd2;
`endif
      end else if (cke_i) begin
         r_state    <= w_state_next;
         r_owner    <= w_owner_next;
         r_cnt      <= w_cnt_next;
         r_rd_pend  <= bd_en_o & ~w_own_wen;
         r_rd_owner <= r_owner;
`ifdef IOB_ETH_BD_ARB_RR_EN
         if (w_state_next == S_OWNED) r_last_owner <= w_owner_next;
`endif
      end
   end

endmodule

// File: tb/tb_iob_eth_bd_arbiter.sv
// Testbench for iob_eth_bd_arbiter: directed scenarios plus randomized traffic against a behavioural model.
// Honours IOB_ETH_BD_ARB_RR_EN when the design is built with it.
module tb_iob_eth_bd_arbiter;
   localparam int AW   = 8;
   localparam int HOLD = 16;
`ifdef IOB_ETH_BD_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic          clk_i, arst_n_i, cke_i;
   logic [2:0]    req_i, wen_i;
   logic [3*AW-1:0] addr_i;
   logic [95:0]   wdata_i;
   logic [2:0]    gnt_o, rvalid_o;
   logic [31:0]   rdata_o, bd_o, bd_i;
   logic [1:0]    owner_o;
   logic          bd_en_o, bd_wen_o;
   logic [AW-1:0] bd_addr_o;

   logic          mem_init;
   logic [31:0]   mem [256];

   int n_checks = 0;
   int n_fail   = 0;

   iob_eth_bd_arbiter #(.BD_ADDR_W(AW), .HOLD_MAX(HOLD)) dut (
      .clk_i(clk_i), .arst_n_i(arst_n_i), .cke_i(cke_i), .req_i(req_i),
      .addr_i(addr_i), .wen_i(wen_i), .wdata_i(wdata_i), .gnt_o(gnt_o),
      .rvalid_o(rvalid_o), .rdata_o(rdata_o), .owner_o(owner_o), .bd_en_o(bd_en_o),
      .bd_addr_o(bd_addr_o), .bd_wen_o(bd_wen_o), .bd_o(bd_o), .bd_i(bd_i)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   function automatic logic [31:0] init_val(input int i);
      return 32'hA5C3_0000 ^ (32'(i) * 32'h0001_0101);
   endfunction

   // BD memory with one-cycle read latency
   always @(posedge clk_i) begin
      if (mem_init) begin
         for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
      end else if (bd_en_o) begin
         if (bd_wen_o) mem[bd_addr_o] <= bd_o;
         else          bd_i <= mem[bd_addr_o];
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic next_cycle();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      arst_n_i = 1'b0; cke_i = 1'b1; req_i = '0; wen_i = '0; addr_i = '0; wdata_i = '0;
      mem_init = 1'b1;
      repeat (2) @(posedge clk_i);
      #1;
      mem_init = 1'b0;
      arst_n_i = 1'b1;
   endtask

   task automatic test_reset();
      arst_n_i = 1'b0; cke_i = 1'b1; mem_init = 1'b1;
      req_i = 3'b111; wen_i = 3'b101; addr_i = 24'h123456; wdata_i = {3{32'hCAFE_F00D}};
      repeat (2) @(posedge clk_i);
      #2;
      n_checks++; if (gnt_o !== 3'b000) begin n_fail++; $display("FAIL reset_gnt got=%b exp=000", gnt_o); end
      n_checks++; if (rvalid_o !== 3'b000) begin n_fail++; $display("FAIL reset_rvalid got=%b exp=000", rvalid_o); end
      n_checks++; if (rdata_o !== 32'd0) begin n_fail++; $display("FAIL reset_rdata got=%h exp=0", rdata_o); end
      n_checks++; if (owner_o !== 2'd3) begin n_fail++; $display("FAIL reset_owner got=%0d exp=3", owner_o); end
      n_checks++; if (bd_en_o !== 1'b0) begin n_fail++; $display("FAIL reset_bd_en got=%b exp=0", bd_en_o); end
      n_checks++; if (bd_addr_o !== 8'd0) begin n_fail++; $display("FAIL reset_bd_addr got=%h exp=0", bd_addr_o); end
      n_checks++; if (bd_wen_o !== 1'b0) begin n_fail++; $display("FAIL reset_bd_wen got=%b exp=0", bd_wen_o); end
      n_checks++; if (bd_o !== 32'd0) begin n_fail++; $display("FAIL reset_bd_o got=%h exp=0", bd_o); end
      $display("test_reset done");
   endtask

   task automatic test_single_read();
      do_reset();
      req_i = 3'b010; wen_i = 3'b000; addr_i = {8'h00, 8'h05, 8'h00};
      @(negedge clk_i);
      n_checks++; if (gnt_o !== 3'b000 || bd_en_o !== 1'b0) begin n_fail++; $display("FAIL rd_select_cycle gnt=%b en=%b exp gnt=000 en=0", gnt_o, bd_en_o); end
      next_cycle(); @(negedge clk_i);
      n_checks++; if (gnt_o !== 3'b010) begin n_fail++; $display("FAIL rd_gnt got=%b exp=010", gnt_o); end
      n_checks++; if (bd_en_o !== 1'b1 || bd_addr_o !== 8'h05 || bd_wen_o !== 1'b0) begin n_fail++; $display("FAIL rd_access en=%b addr=%h wen=%b exp en=1 addr=05 wen=0", bd_en_o, bd_addr_o, bd_wen_o); end
      next_cycle(); req_i = 3'b000; @(negedge clk_i);
      n_checks++; if (rvalid_o !== 3'b010) begin n_fail++; $display("FAIL rd_rvalid got=%b exp=010", rvalid_o); end
      n_checks++; if (rdata_o !== init_val(5)) begin n_fail++; $display("FAIL rd_rdata got=%h exp=%h", rdata_o, init_val(5)); end
      next_cycle(); @(negedge clk_i);
      n_checks++; if (gnt_o !== 3'b000 || rvalid_o !== 3'b000) begin n_fail++; $display("FAIL rd_release gnt=%b rvalid=%b exp 000/000", gnt_o, rvalid_o); end
      $display("test_single_read done");
   endtask

   task automatic test_priority_handoff();
      logic [2:0] exp_seq [3];
      exp_seq[0] = 3'b001; exp_seq[1] = 3'b010; exp_seq[2] = 3'b100;
      do_reset();
      req_i = 3'b111; wen_i = 3'b000; addr_i = {8'h30, 8'h20, 8'h10};
      next_cycle();
      for (int g = 0; g < 3; g++) begin
         @(negedge clk_i);
         n_checks++; if (gnt_o !== exp_seq[g] || bd_en_o !== 1'b1) begin n_fail++; $display("FAIL handoff_grant%0d gnt=%b en=%b exp gnt=%b en=1", g, gnt_o, bd_en_o, exp_seq[g]); end
         next_cycle();
         req_i = req_i & ~exp_seq[g];
         @(negedge clk_i);
         n_checks++; if (gnt_o !== exp_seq[g] || bd_en_o !== 1'b0) begin n_fail++; $display("FAIL handoff_release%0d gnt=%b en=%b exp gnt=%b en=0", g, gnt_o, bd_en_o, exp_seq[g]); end
         next_cycle();
      end
      @(negedge clk_i);
      n_checks++; if (gnt_o !== 3'b000) begin n_fail++; $display("FAIL handoff_idle gnt=%b exp=000", gnt_o); end
      $display("test_priority_handoff done");
   endtask

   task automatic test_hold_revoke();
      int c = 0;
      int guard = 0;
      do_reset();
      req_i = 3'b100; wen_i = 3'b000; addr_i = {8'h20, 8'h40, 8'h00};
      next_cycle();
      req_i = 3'b110;
      @(negedge clk_i);
      n_checks++; if (gnt_o !== 3'b100) begin n_fail++; $display("FAIL hold_first_gnt got=%b exp=100", gnt_o); end
      while (gnt_o === 3'b100 && guard < HOLD + 8) begin
         if (bd_en_o) c++;
         guard++;
         next_cycle(); @(negedge clk_i);
      end
      n_checks++; if (c != HOLD) begin n_fail++; $display("FAIL hold_tx_accesses got=%0d exp=%0d", c, HOLD); end
      n_checks++; if (gnt_o !== 3'b010) begin n_fail++; $display("FAIL hold_next_gnt got=%b exp=010", gnt_o); end
      n_checks++; if (rvalid_o !== 3'b100 || rdata_o !== init_val(32'h20)) begin n_fail++; $display("FAIL hold_last_read rvalid=%b rdata=%h exp 100/%h", rvalid_o, rdata_o, init_val(32'h20)); end
      req_i = 3'b000;
      next_cycle(); next_cycle();
      $display("test_hold_revoke done");
   endtask

   task automatic test_all_hold();
      int exp_own [4];
      int c;
      if (RR) begin exp_own[0] = 0; exp_own[1] = 1; exp_own[2] = 2; exp_own[3] = 0; end
      else    begin exp_own[0] = 0; exp_own[1] = 1; exp_own[2] = 0; exp_own[3] = 1; end
      do_reset();
      req_i = 3'b111; wen_i = 3'b000; addr_i = {8'h03, 8'h02, 8'h01};
      next_cycle(); @(negedge clk_i);
      for (int t = 0; t < 4; t++) begin
         c = 0;
         while (int'(owner_o) == exp_own[t] && bd_en_o === 1'b1 && c < HOLD + 4) begin
            c++;
            next_cycle(); @(negedge clk_i);
         end
         n_checks++; if (c != HOLD) begin n_fail++; $display("FAIL all_hold_tenure%0d owner_exp=%0d accesses=%0d exp=%0d now_owner=%0d", t, exp_own[t], c, HOLD, owner_o); end
      end
      req_i = 3'b000;
      next_cycle(); next_cycle();
      $display("test_all_hold done");
   endtask

   task automatic test_write_read();
      do_reset();
      req_i = 3'b001; wen_i = 3'b001; addr_i = {8'h00, 8'h00, 8'h03}; wdata_i = {64'd0, 32'hDEAD_BEEF};
      next_cycle(); @(negedge clk_i);
      n_checks++; if (bd_en_o !== 1'b1 || bd_wen_o !== 1'b1 || bd_o !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wr_cycle en=%b wen=%b data=%h exp 1/1/deadbeef", bd_en_o, bd_wen_o, bd_o); end
      next_cycle(); wen_i = 3'b000; @(negedge clk_i);
      n_checks++; if (bd_en_o !== 1'b1 || bd_wen_o !== 1'b0 || rvalid_o !== 3'b000) begin n_fail++; $display("FAIL wr_read_cycle en=%b wen=%b rvalid=%b exp 1/0/000", bd_en_o, bd_wen_o, rvalid_o); end
      next_cycle(); req_i = 3'b000; @(negedge clk_i);
      n_checks++; if (rvalid_o !== 3'b001 || rdata_o !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wr_readback rvalid=%b rdata=%h exp 001/deadbeef", rvalid_o, rdata_o); end
      next_cycle();
      $display("test_write_read done");
   endtask

   task automatic test_reset_abort();
      int seen = 0;
      do_reset();
      req_i = 3'b001; wen_i = 3'b000; addr_i = {8'h00, 8'h00, 8'h07};
      next_cycle(); next_cycle();
      #2;
      arst_n_i = 1'b0;
      #1;
      n_checks++; if (gnt_o !== 3'b000 || owner_o !== 2'd3) begin n_fail++; $display("FAIL abort_grant gnt=%b owner=%0d exp 000/3", gnt_o, owner_o); end
      n_checks++; if (rvalid_o !== 3'b000 || rdata_o !== 32'd0) begin n_fail++; $display("FAIL abort_rvalid rvalid=%b rdata=%h exp 000/0", rvalid_o, rdata_o); end
      n_checks++; if (bd_en_o !== 1'b0 || bd_addr_o !== 8'd0 || bd_wen_o !== 1'b0 || bd_o !== 32'd0) begin n_fail++; $display("FAIL abort_bd en=%b addr=%h wen=%b data=%h exp all 0", bd_en_o, bd_addr_o, bd_wen_o, bd_o); end
      req_i = 3'b000;
      repeat (2) @(posedge clk_i);
      #1; arst_n_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         if (rvalid_o !== 3'b000) seen++;
      end
      n_checks++; if (seen != 0) begin n_fail++; $display("FAIL abort_no_rvalid pulses=%0d exp=0", seen); end
      $display("test_reset_abort done");
   endtask

   function automatic int choose(input logic [2:0] cand, input int last);
      int start;
      start = RR ? (last + 1) % 3 : 0;
      for (int k = 0; k < 3; k++) begin
         if (cand[(start + k) % 3]) return (start + k) % 3;
      end
      return -1;
   endfunction

   task automatic test_random();
      logic [AW-1:0] a_addr [3];
      logic [31:0]   a_wd [3];
      logic [2:0]    a_req, a_wen, comp;
      logic [31:0]   m_mem [256];
      int            m_owner, m_cnt, m_last, m_rv_who;
      bit            m_rv;
      logic [31:0]   m_rv_data;
      logic [2:0]    e_gnt, e_rv;
      logic [1:0]    e_owner;
      logic          e_en, e_wen;
      logic [AW-1:0] e_addr;
      logic [31:0]   e_bd, e_rdata;
      int            errs0;

      do_reset();
      for (int i = 0; i < 256; i++) m_mem[i] = init_val(i);
      m_owner = -1; m_cnt = 0; m_last = 2; m_rv = 0; m_rv_who = 0; m_rv_data = '0;
      a_req = '0; a_wen = '0;
      errs0 = n_fail;

      for (int cyc = 0; cyc < 2000; cyc++) begin
         for (int n = 0; n < 3; n++) begin
            if (a_req[n]) begin
               if ($urandom_range(7) == 0) a_req[n] = 1'b0;
            end else if ($urandom_range(3) == 0) begin
               a_req[n] = 1'b1;
            end
            a_addr[n] = 8'($urandom);
            a_wd[n]   = $urandom;
            a_wen[n]  = ($urandom_range(2) == 0);
         end
         cke_i   = ($urandom_range(9) != 0);
         req_i   = a_req;
         wen_i   = a_wen;
         addr_i  = {a_addr[2], a_addr[1], a_addr[0]};
         wdata_i = {a_wd[2], a_wd[1], a_wd[0]};
         @(negedge clk_i);

         e_gnt = '0; e_owner = 2'd3; e_en = 1'b0; e_wen = 1'b0; e_addr = '0; e_bd = '0;
         if (m_owner >= 0) begin
            e_gnt[m_owner] = 1'b1;
            e_owner = 2'(m_owner);
            e_en    = a_req[m_owner] && cke_i;
            e_wen   = e_en && a_wen[m_owner];
            e_addr  = a_addr[m_owner];
            e_bd    = a_wd[m_owner];
         end
         e_rv = '0; e_rdata = '0;
         if (m_rv && cke_i) begin e_rv[m_rv_who] = 1'b1; e_rdata = m_rv_data; end

         n_checks++; if (gnt_o !== e_gnt) begin n_fail++; $display("FAIL rnd_gnt cyc=%0d got=%b exp=%b", cyc, gnt_o, e_gnt); end
         n_checks++; if (owner_o !== e_owner) begin n_fail++; $display("FAIL rnd_owner cyc=%0d got=%0d exp=%0d", cyc, owner_o, e_owner); end
         n_checks++; if (bd_en_o !== e_en) begin n_fail++; $display("FAIL rnd_bd_en cyc=%0d got=%b exp=%b", cyc, bd_en_o, e_en); end
         n_checks++; if (bd_wen_o !== e_wen) begin n_fail++; $display("FAIL rnd_bd_wen cyc=%0d got=%b exp=%b", cyc, bd_wen_o, e_wen); end
         n_checks++; if (bd_addr_o !== e_addr) begin n_fail++; $display("FAIL rnd_bd_addr cyc=%0d got=%h exp=%h", cyc, bd_addr_o, e_addr); end
         n_checks++; if (bd_o !== e_bd) begin n_fail++; $display("FAIL rnd_bd_o cyc=%0d got=%h exp=%h", cyc, bd_o, e_bd); end
         n_checks++; if (rvalid_o !== e_rv) begin n_fail++; $display("FAIL rnd_rvalid cyc=%0d got=%b exp=%b", cyc, rvalid_o, e_rv); end
         n_checks++; if (rdata_o !== e_rdata) begin n_fail++; $display("FAIL rnd_rdata cyc=%0d got=%h exp=%h", cyc, rdata_o, e_rdata); end

         if (cke_i) begin
            m_rv = 1'b0;
            if (e_en) begin
               if (a_wen[m_owner]) begin
                  m_mem[a_addr[m_owner]] = a_wd[m_owner];
               end else begin
                  m_rv      = 1'b1;
                  m_rv_who  = m_owner;
                  m_rv_data = m_mem[a_addr[m_owner]];
               end
            end
            if (m_owner < 0) begin
               if (a_req != 3'b000) begin m_owner = choose(a_req, m_last); m_cnt = 0; end
            end else begin
               comp = a_req;
               comp[m_owner] = 1'b0;
               if (!a_req[m_owner]) begin
                  m_owner = choose(comp, m_last);
                  m_cnt = 0;
               end else if (comp != 3'b000) begin
                  if (HOLD > 0 && m_cnt == HOLD - 1) begin
                     m_owner = choose(comp, m_last);
                     m_cnt = 0;
                  end else begin
                     m_cnt++;
                  end
               end
            end
            if (m_owner >= 0) m_last = m_owner;
         end
         next_cycle();
      end
      cke_i = 1'b1;
      req_i = '0;
      next_cycle(); next_cycle();
      $display("test_random done: 2000 cycles, %0d new failures", n_fail - errs0);
   endtask

   initial begin
      arst_n_i = 1'b0; cke_i = 1'b1; mem_init = 1'b0;
      req_i = '0; wen_i = '0; addr_i = '0; wdata_i = '0;
      test_reset();
      test_single_read();
      test_priority_handoff();
      test_hold_revoke();
      test_all_hold();
      test_write_read();
      test_reset_abort();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
